// File: rtl/mem_arbiter.sv
// Round-robin arbiter that sequences a single-port synchronous RAM between two requesters.
// state | meaning: IDLE grant | ISSUE strobe RAM | WAIT read latency | ACK pulse winner ack
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state;
  logic              cmd_we;
  logic              winner;
  logic [2:0]        lat_cnt;
  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_hi_unused;

  // On a tie the port that was not served last wins.
  assign grant_b        = b_req && (!a_req || !last_grant);
  assign sel_we         = grant_b ? b_we : a_we;
  assign sel_addr       = grant_b ? b_addr[ADDR_W-1:0] : a_addr[ADDR_W-1:0];
  assign sel_wdata      = grant_b ? b_wdata : a_wdata;
  assign addr_hi_unused = ^{a_addr[31:ADDR_W], b_addr[31:ADDR_W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_we     <= 1'b0;
      winner     <= 1'b0;
      lat_cnt    <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: begin
          // Command registers double as the RAM pins so ISSUE drives them directly.
          if (a_req || b_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            winner    <= grant_b;
            cmd_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            mem_re    <= !sel_we;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state      <= ACK;
            a_ack      <= !winner;
            b_ack      <= winner;
            last_grant <= winner;
          end else begin
            state   <= WAIT;
            lat_cnt <= 3'(RD_LAT);
          end
        end
        WAIT: begin
          if (lat_cnt <= 3'd1) begin
            state      <= ACK;
            a_ack      <= !winner;
            b_ack      <= winner;
            last_grant <= winner;
            if (winner) b_rdata <= mem_rdata;
            else        a_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port synchronous main memory and shares it between two requesters.
- Port A is the CPU core memory interface (driven from MAR/MDR with Read/write_mem).
- Port B is the program loader / debug port.
- Grants one access at a time with round-robin priority, drives the RAM control pins, returns read data and a one-cycle ack per request.

Parameters:
ADDR_W, 9, memory word-address width; requester addresses are truncated to the low ADDR_W bits
DATA_W, 32, data word width
RD_LAT, 1, RAM read latency in cycles (1..4) from the issue cycle to valid mem_rdata

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
a_req  input  1  port A request; held high until a_ack
a_we  input  1  port A: 1 = write, 0 = read; stable while a_req
a_addr  input  32  port A word address (low ADDR_W bits used)
a_wdata  input  DATA_W  port A write data
a_rdata  output  DATA_W  port A read data, valid from a_ack, held until next A read completes
a_ack  output  1  port A one-cycle completion pulse
b_req, b_we, b_addr, b_wdata, b_rdata, b_ack  (same widths/meanings for port B)
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_we  output  1  RAM write strobe
mem_re  output  1  RAM read strobe
mem_rdata  input  DATA_W  RAM read data
busy  output  1  high in any state other than IDLE
last_grant  output  1  0 = A served last, 1 = B served last

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - a_ack=b_ack=mem_we=mem_re=busy=0; mem_addr=0, mem_wdata=0, a_rdata=b_rdata=0.
  - last_grant=1, so A wins the first tie.
  - Reset mid-access aborts it: no ack, no strobe on the following cycle.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - On each rising edge, sample a_req/b_req.
  - Only one requesting: it wins.
  - Both requesting: the port not equal to last_grant wins.
  - Winner's we/addr[ADDR_W-1:0]/wdata latch into the command registers and the winner id is latched; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle): mem_addr/mem_wdata = latched values; mem_we=1 for a write, mem_re=1 for a read, never both.
  - Write: go to ACK.
  - Read: go to WAIT with the latency counter loaded to RD_LAT.
- WAIT: strobes low, mem_addr held; count down. On the edge where the count reaches 0, capture mem_rdata into the winner's rdata register; go to ACK.
- ACK (exactly 1 cycle):
  - Winner's ack=1 (the other ack stays 0); last_grant := winner.
  - Next state is IDLE. No new grant is taken in the ACK cycle.
- Latency, counted from the edge that samples req in IDLE:
  - Write: ack is high 2 cycles later.
  - Read: ack is high RD_LAT+2 cycles later, with rdata valid in the same cycle as ack.
- Requester rule: drop req on the edge after seeing ack. Because IDLE samples one edge later, a dropped req is never re-granted. A req still high is a new request.
- Starvation bound: with both ports continuously requesting, service alternates A,B,A,B…
- Non-winner rdata is never modified. Changes to a_we/a_addr/a_wdata after the grant edge are ignored.
- Address bits above ADDR_W-1 are ignored (wrap-around); no error is reported.
- mem_addr and mem_wdata hold their last values in IDLE.

Test Plan:
- Reset with reset=0 mid-WAIT (A read in flight, mem_rdata=32'hDEAD) -> a_ack never pulses, mem_re=0, busy=0, a_rdata=0 after release; the next A request is granted normally.
- A write addr=5, data=32'h1234_5678 -> mem_we=1 with mem_addr=5 exactly one cycle, a_ack 2 cycles after sample; then A read addr=5 (RD_LAT=1) -> a_rdata=32'h1234_5678 with a_ack 3 cycles after sample.
- a_req and b_req rise together right after reset (A read addr 7, B write addr 9 data 32'hCAFE) -> A served first, then B; mem_we never overlaps mem_re; b_rdata unchanged.
- Both held continuously for 4 transactions -> ack order A,B,A,B; last_grant toggles 0,1,0,1.
- a_addr=32'h0000_0203 with ADDR_W=9 -> mem_addr=9'h003.
- RD_LAT=3 build, B read -> exactly 3 WAIT cycles, b_ack 5 cycles after sample, captured data equals mem_rdata at the final WAIT edge.
